otp_part_buf_ctrl: RTL and testbench
====================================

Name: otp_part_buf_ctrl

Overview:
Sequences the initial readout of one buffered OTP partition into its part_buf_data register. On an init request it fetches NumWords data words plus one digest word from the OTP macro over a req/gnt/rvalid handshake, then checks an XOR digest. It publishes the buffer as valid, or on any error substitutes the partition's invalid-default value. It sits between the OTP macro read port and the partition consumers.

Parameters:
NumWords, 4, number of data words in the partition (>=1)
WordW, 32, OTP word width in bits
AddrW, 11, OTP word address width
BaseAddr, 0, word address of the first partition word; digest word is at BaseAddr+NumWords
InvDefault, all-zero (NumWords*WordW bits), value driven on part_data_o when the partition is invalid

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
init_req_i  input  1  level request to start readout, sampled in IDLE only
init_done_o  output  1  one-cycle pulse when readout finishes, pass or fail
otp_req_o  output  1  read request to OTP macro
otp_addr_o  output  AddrW  word address of current request
otp_gnt_i  input  1  macro accepted the request this cycle
otp_rvalid_i  input  1  read data valid
otp_rdata_i  input  WordW  read data
otp_err_i  input  1  macro error, qualified by otp_rvalid_i
part_data_o  output  NumWords*WordW  partition buffer; word k at bits [k*WordW +: WordW]
part_valid_o  output  1  buffer contents verified
part_err_o  output  1  sticky partition error

Behaviour:
- Clock clk_i, reset rst_i: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, otp_req_o=0, otp_addr_o=0, init_done_o=0, part_valid_o=0, part_err_o=0, internal buffer=InvDefault, word counter=0, digest accumulator=0.
- part_data_o = buffer when part_valid_o=1, else InvDefault. Partial data is never exposed.
- States:
  - IDLE: if init_req_i=1, clear counter and accumulator, clear part_valid_o and part_err_o, go to REQ.
  - REQ: otp_req_o=1, otp_addr_o=BaseAddr+counter. Hold address and request stable until otp_gnt_i=1. On gnt, go to WAIT; otp_req_o drops the next cycle. Only one outstanding read at a time.
  - WAIT: wait for otp_rvalid_i. If otp_err_i=1, go to ERROR. Else, if counter<NumWords, store word[counter], accumulator ^= otp_rdata_i, increment counter, go to REQ. If counter==NumWords (digest word), latch the digest and go to CHECK.
  - CHECK (1 cycle): if accumulator==digest, part_valid_o=1 and go to DONE. Else go to ERROR.
  - ERROR (1 cycle): part_err_o=1, buffer reloaded with InvDefault, part_valid_o=0, go to DONE.
  - DONE: init_done_o=1 for exactly one cycle, then IDLE.
- otp_rvalid_i in IDLE/REQ/DONE/CHECK/ERROR is ignored.
- otp_gnt_i is only honoured while otp_req_o=1.
- Minimum latency, with gnt and rvalid each arriving one cycle after entry: 2*(NumWords+1) cycles from leaving IDLE to CHECK, plus 1 to DONE. The done pulse arrives 2*NumWords+4 cycles after init_req_i is sampled.
- part_err_o is sticky until the next accepted init_req_i or reset. part_valid_o holds across IDLE until the next init.
- init_req_i asserted while busy is ignored. It is re-sampled only in IDLE; a held-high level restarts readout after DONE.
- Reset mid-operation: everything returns to reset values next cycle, including dropping otp_req_o even if not granted.
- Counter width is $clog2(NumWords+1). Address arithmetic wraps modulo 2^AddrW.

Test Plan:
- NumWords=4, BaseAddr=0x10, words 0x11111111, 0x22222222, 0x44444444, 0x88888888, digest 0xFFFFFFFF, gnt/rvalid next cycle -> addresses 0x10..0x14 in order, part_valid_o=1, part_data_o={0x88888888,0x44444444,0x22222222,0x11111111}, init_done_o pulse 12 cycles after request.
- Same data, digest 0xFFFFFFFE -> part_err_o=1, part_valid_o=0, part_data_o=InvDefault, single init_done_o pulse.
- otp_err_i=1 with rvalid on word 2 -> no further requests issued, part_err_o=1, part_data_o=InvDefault.
- gnt withheld 5 cycles on word 1 -> otp_req_o and otp_addr_o=0x11 stable for all 5 cycles, result unchanged from the first scenario.
- rst_i pulsed while in WAIT for word 3 -> next cycle otp_req_o=0, part_valid_o=0, part_err_o=0, part_data_o=InvDefault. A fresh init then passes.
- Error run followed by a good init -> part_err_o clears on acceptance of the init, part_valid_o=1 at the end.

Source files
------------

// File: rtl/otp_part_buf_ctrl_if.sv
// OTP macro read port: single-outstanding req/gnt request channel plus rvalid response channel.
// The controller is the master; the OTP macro (or its model) is the slave.
interface otp_part_buf_ctrl_if #(
    parameter int unsigned AddrW = 11,
    parameter int unsigned WordW = 32
);
    logic             otp_req_o;
    logic [AddrW-1:0] otp_addr_o;
    logic             otp_gnt_i;
    logic             otp_rvalid_i;
    logic [WordW-1:0] otp_rdata_i;
    logic             otp_err_i;

    modport master (
        output otp_req_o,
        output otp_addr_o,
        input  otp_gnt_i,
        input  otp_rvalid_i,
        input  otp_rdata_i,
        input  otp_err_i
    );

    modport slave (
        input  otp_req_o,
        input  otp_addr_o,
        output otp_gnt_i,
        output otp_rvalid_i,
        output otp_rdata_i,
        output otp_err_i
    );
endinterface

// File: rtl/otp_part_buf_ctrl.sv
// Reads NumWords data words plus an XOR digest word of one OTP partition into a buffer,
// then publishes the buffer as valid or falls back to InvDefault on any error.
module otp_part_buf_ctrl #(
    parameter int unsigned                NumWords   = 4,
    parameter int unsigned                WordW      = 32,
    parameter int unsigned                AddrW      = 11,
    parameter logic [AddrW-1:0]           BaseAddr   = '0,
    parameter logic [NumWords*WordW-1:0]  InvDefault = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          init_req_i,
    output logic                          init_done_o,
    otp_part_buf_ctrl_if.master           otp,
    output logic [NumWords*WordW-1:0]     part_data_o,
    output logic                          part_valid_o,
    output logic                          part_err_o
);
    localparam int unsigned CntW = $clog2(NumWords + 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StCheck,
        StError,
        StDone
    } state_e;

    state_e                      state_q, state_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [WordW-1:0]            acc_q, acc_d;
    logic [WordW-1:0]            dig_q, dig_d;
    logic [NumWords*WordW-1:0]   buf_q, buf_d;
    logic                        valid_q, valid_d;
    logic                        err_q, err_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            dig_q   <= '0;
            buf_q   <= InvDefault;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dig_q   <= dig_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        dig_d          = dig_q;
        buf_d          = buf_q;
        valid_d        = valid_q;
        err_d          = err_q;
        otp.otp_req_o  = 1'b0;
        otp.otp_addr_o = '0;
        init_done_o    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (init_req_i) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                otp.otp_req_o  = 1'b1;
                otp.otp_addr_o = BaseAddr + AddrW'(cnt_q);
                if (otp.otp_gnt_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (otp.otp_rvalid_i) begin
                    if (otp.otp_err_i) begin
                        state_d = StError;
                    end else if (cnt_q < CntW'(NumWords)) begin
                        for (int unsigned k = 0; k < NumWords; k++) begin
                            if (CntW'(k) == cnt_q) begin
                                buf_d[k*WordW +: WordW] = otp.otp_rdata_i;
                            end
                        end
                        acc_d   = acc_q ^ otp.otp_rdata_i;
                        cnt_d   = cnt_q + CntW'(1);
                        state_d = StReq;
                    end else begin
                        // Counter has reached NumWords: this response is the digest word.
                        dig_d   = otp.otp_rdata_i;
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (acc_q == dig_q) begin
                    valid_d = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StError;
                end
            end
            StError: begin
                err_d   = 1'b1;
                valid_d = 1'b0;
                buf_d   = InvDefault;
                state_d = StDone;
            end
            StDone: begin
                init_done_o = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Buffer is only exposed once verified, so partial readouts never leak out.
    assign part_data_o  = valid_q ? buf_q : InvDefault;
    assign part_valid_o = valid_q;
    assign part_err_o   = err_q;
endmodule

// File: tb/tb_otp_part_buf_ctrl.sv
// Self-checking bench for otp_part_buf_ctrl: the bench plays the OTP macro and predicts
// each readout outcome from the planned word/digest/error pattern.
module tb_otp_part_buf_ctrl;
    localparam int unsigned NW = 4;
    localparam int unsigned WW = 32;
    localparam int unsigned AW = 11;
    localparam logic [AW-1:0]    BASE = 11'h010;
    localparam logic [NW*WW-1:0] INV  = {NW{32'hDEADBEEF}};

    logic clk = 1'b0;
    logic rst;
    logic init_req;
    logic init_done;
    logic [NW*WW-1:0] part_data;
    logic part_valid;
    logic part_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Planned macro contents for the next readout: words 0..NW-1 then the digest at NW.
    logic [WW-1:0] pw [NW+1];
    // Grant delay (in cycles of held request) per word.
    int pg [NW+1];

    otp_part_buf_ctrl_if #(.AddrW(AW), .WordW(WW)) otp_bus ();

    otp_part_buf_ctrl #(
        .NumWords  (NW),
        .WordW     (WW),
        .AddrW     (AW),
        .BaseAddr  (BASE),
        .InvDefault(INV)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .init_req_i  (init_req),
        .init_done_o (init_done),
        .otp         (otp_bus.master),
        .part_data_o (part_data),
        .part_valid_o(part_valid),
        .part_err_o  (part_err)
    );

    always #5 clk = ~clk;

    function automatic bit model_pass(input int err_idx);
        logic [WW-1:0] x;
        if (err_idx >= 0 && err_idx <= int'(NW)) return 1'b0;
        x = '0;
        for (int i = 0; i < int'(NW); i++) x = x ^ pw[i];
        return x == pw[NW];
    endfunction

    function automatic logic [NW*WW-1:0] model_data(input bit pass);
        logic [NW*WW-1:0] d;
        if (!pass) return INV;
        for (int i = 0; i < int'(NW); i++) d[i*WW +: WW] = pw[i];
        return d;
    endfunction

    function automatic int model_done_edge(input int err_idx, input bit pass);
        if (err_idx >= 0 && err_idx <= int'(NW)) return 2 * (err_idx + 1) + 2;
        return pass ? 2 * int'(NW) + 4 : 2 * int'(NW) + 5;
    endfunction

    // Acts as the OTP macro for one readout. Returns the edge (counting the init sampling
    // edge as 1) at which done was first seen, and leaves the DUT one cycle past DONE.
    task automatic run_readout(input int err_idx, input int rdly, input int rst_word,
                               input bit rand_init, output int done_at, output bit finished);
        int wi = 0;
        int phase = 0;
        int hold = 0;
        int holdr = 0;
        int nreq = 0;
        int edges;
        bit extra = 1'b0;
        bit aborted = 1'b0;
        int exp_nreq;
        logic [AW-1:0] ea;
        finished = 1'b0;
        done_at = 0;
        otp_bus.otp_gnt_i    = 1'b0;
        otp_bus.otp_rvalid_i = 1'b0;
        otp_bus.otp_err_i    = 1'b0;
        init_req = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        n_tests++;
        if (part_valid !== 1'b0 || part_err !== 1'b0) begin
            n_fail++;
            $display("FAIL init_clear: valid=%0b err=%0b, required 0/0", part_valid, part_err);
        end
        while (!finished && !aborted && edges < 500) begin
            init_req = rand_init ? 1'($urandom_range(0, 1)) : 1'b0;
            otp_bus.otp_gnt_i    = 1'b0;
            otp_bus.otp_rvalid_i = 1'($urandom_range(0, 1));
            otp_bus.otp_err_i    = 1'($urandom_range(0, 1));
            otp_bus.otp_rdata_i  = $urandom;
            if (init_done === 1'b1) begin
                finished = 1'b1;
                done_at  = edges;
                init_req = 1'b0;
                otp_bus.otp_rvalid_i = 1'b0;
            end else begin
                case (phase)
                    0: begin
                        if (wi <= int'(NW)) begin
                            ea = BASE + AW'(wi);
                            n_tests++;
                            if (otp_bus.otp_req_o !== 1'b1 || otp_bus.otp_addr_o !== ea) begin
                                n_fail++;
                                $display("FAIL req_addr word %0d: req=%0b addr=%h, required 1/%h",
                                         wi, otp_bus.otp_req_o, otp_bus.otp_addr_o, ea);
                            end
                            if (hold == 0) nreq++;
                            if (hold >= pg[wi]) begin
                                otp_bus.otp_gnt_i = 1'b1;
                                phase = 1;
                                holdr = 0;
                            end else begin
                                hold++;
                            end
                        end else if (otp_bus.otp_req_o === 1'b1) begin
                            extra = 1'b1;
                        end
                    end
                    1: begin
                        n_tests++;
                        if (otp_bus.otp_req_o !== 1'b0) begin
                            n_fail++;
                            $display("FAIL one_outstanding word %0d: req=%0b, required 0",
                                     wi, otp_bus.otp_req_o);
                        end
                        if (wi == rst_word) begin
                            rst = 1'b1;
                            aborted = 1'b1;
                        end else if (holdr >= rdly) begin
                            otp_bus.otp_rvalid_i = 1'b1;
                            otp_bus.otp_rdata_i  = pw[wi];
                            otp_bus.otp_err_i    = (wi == err_idx);
                            if (wi == err_idx) begin
                                phase = 2;
                            end else begin
                                wi++;
                                phase = 0;
                                hold = 0;
                            end
                        end else begin
                            otp_bus.otp_rvalid_i = 1'b0;
                            holdr++;
                        end
                    end
                    default: begin
                        if (otp_bus.otp_req_o === 1'b1) extra = 1'b1;
                    end
                endcase
            end
            @(posedge clk); #1;
            edges++;
        end
        otp_bus.otp_rvalid_i = 1'b0;
        otp_bus.otp_gnt_i    = 1'b0;
        init_req = 1'b0;
        if (aborted) begin
            rst = 1'b0;
        end else if (!finished) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: no init_done within %0d cycles", edges);
        end else begin
            exp_nreq = (err_idx >= 0 && err_idx <= int'(NW)) ? err_idx + 1 : int'(NW) + 1;
            n_tests++;
            if (init_done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse: init_done=%0b one cycle after DONE, required 0", init_done);
            end
            n_tests++;
            if (nreq != exp_nreq || extra) begin
                n_fail++;
                $display("FAIL req_count: %0d requests (extra=%0b), required %0d (extra=0)",
                         nreq, extra, exp_nreq);
            end
        end
    endtask

    task automatic set_directed(input logic [WW-1:0] digest);
        pw[0] = 32'h11111111;
        pw[1] = 32'h22222222;
        pw[2] = 32'h44444444;
        pw[3] = 32'h88888888;
        pw[4] = digest;
        for (int i = 0; i <= int'(NW); i++) pg[i] = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        init_req = 1'b0;
        otp_bus.otp_gnt_i = 1'b0;
        otp_bus.otp_rvalid_i = 1'b0;
        otp_bus.otp_err_i = 1'b0;
        otp_bus.otp_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (otp_bus.otp_req_o !== 1'b0 || otp_bus.otp_addr_o !== '0 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus: req=%0b addr=%h done=%0b, required 0/0/0",
                     otp_bus.otp_req_o, otp_bus.otp_addr_o, init_done);
        end
        n_tests++;
        if (part_valid !== 1'b0 || part_err !== 1'b0 || part_data !== INV) begin
            n_fail++;
            $display("FAIL reset_part: valid=%0b err=%0b data=%h, required 0/0/%h",
                     part_valid, part_err, part_data, INV);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_good_readout;
        int done_at;
        bit fin;
        set_directed(32'hFFFFFFFF);
        run_readout(-1, 0, -1, 1'b0, done_at, fin);
        n_tests++;
        if (done_at != 2 * int'(NW) + 4) begin
            n_fail++;
            $display("FAIL good_latency: done at edge %0d, required %0d", done_at, 2 * NW + 4);
        end
        n_tests++;
        if (part_valid !== 1'b1 || part_err !== 1'b0 ||
            part_data !== 128'h88888888_44444444_22222222_11111111) begin
            n_fail++;
            $display("FAIL good_result: valid=%0b err=%0b data=%h, required 1/0/%h",
                     part_valid, part_err, part_data, 128'h88888888_44444444_22222222_11111111);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (part_valid !== 1'b1 || part_data !== model_data(1'b1)) begin
            n_fail++;
            $display("FAIL good_hold_idle: valid=%0b data=%h, required 1/%h",
                     part_valid, part_data, model_data(1'b1));
        end
    endtask

    task automatic test_bad_digest;
        int done_at;
        bit fin;
        set_directed(32'hFFFFFFFE);
        run_readout(-1, 0, -1, 1'b0, done_at, fin);
        n_tests++;
        if (done_at != 2 * int'(NW) + 5) begin
            n_fail++;
            $display("FAIL bad_digest_latency: done at edge %0d, required %0d", done_at, 2 * NW + 5);
        end
        n_tests++;
        if (part_valid !== 1'b0 || part_err !== 1'b1 || part_data !== INV) begin
            n_fail++;
            $display("FAIL bad_digest_result: valid=%0b err=%0b data=%h, required 0/1/%h",
                     part_valid, part_err, part_data, INV);
        end
    endtask

    task automatic test_otp_err;
        int done_at;
        bit fin;
        set_directed(32'hFFFFFFFF);
        run_readout(2, 0, -1, 1'b0, done_at, fin);
        n_tests++;
        if (done_at != model_done_edge(2, 1'b0)) begin
            n_fail++;
            $display("FAIL otp_err_latency: done at edge %0d, required %0d", done_at, model_done_edge(2, 1'b0));
        end
        n_tests++;
        if (part_valid !== 1'b0 || part_err !== 1'b1 || part_data !== INV) begin
            n_fail++;
            $display("FAIL otp_err_result: valid=%0b err=%0b data=%h, required 0/1/%h",
                     part_valid, part_err, part_data, INV);
        end
    endtask

    task automatic test_gnt_stall;
        int done_at;
        bit fin;
        set_directed(32'hFFFFFFFF);
        pg[1] = 5;
        run_readout(-1, 0, -1, 1'b0, done_at, fin);
        n_tests++;
        if (done_at != 2 * int'(NW) + 4 + 5) begin
            n_fail++;
            $display("FAIL stall_latency: done at edge %0d, required %0d", done_at, 2 * NW + 9);
        end
        n_tests++;
        if (part_valid !== 1'b1 || part_err !== 1'b0 || part_data !== model_data(1'b1)) begin
            n_fail++;
            $display("FAIL stall_result: valid=%0b err=%0b data=%h, required 1/0/%h",
                     part_valid, part_err, part_data, model_data(1'b1));
        end
    endtask

    task automatic test_reset_mid;
        int done_at;
        bit fin;
        set_directed(32'hFFFFFFFF);
        run_readout(-1, 2, 3, 1'b0, done_at, fin);
        n_tests++;
        if (otp_bus.otp_req_o !== 1'b0 || part_valid !== 1'b0 || part_err !== 1'b0 ||
            part_data !== INV || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: req=%0b valid=%0b err=%0b done=%0b data=%h, required 0/0/0/0/%h",
                     otp_bus.otp_req_o, part_valid, part_err, init_done, part_data, INV);
        end
        @(posedge clk); #1;
        run_readout(-1, 0, -1, 1'b0, done_at, fin);
        n_tests++;
        if (part_valid !== 1'b1 || part_err !== 1'b0 || part_data !== model_data(1'b1)) begin
            n_fail++;
            $display("FAIL reset_mid_rerun: valid=%0b err=%0b data=%h, required 1/0/%h",
                     part_valid, part_err, part_data, model_data(1'b1));
        end
    endtask

    task automatic test_err_then_good;
        int done_at;
        bit fin;
        set_directed(32'h0BADF00D);
        run_readout(-1, 1, -1, 1'b0, done_at, fin);
        n_tests++;
        if (part_err !== 1'b1 || part_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_first: valid=%0b err=%0b, required 0/1", part_valid, part_err);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (part_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: err=%0b while idle, required 1", part_err);
        end
        set_directed(32'hFFFFFFFF);
        run_readout(-1, 0, -1, 1'b0, done_at, fin);
        n_tests++;
        if (part_valid !== 1'b1 || part_err !== 1'b0 || part_data !== model_data(1'b1)) begin
            n_fail++;
            $display("FAIL err_then_good: valid=%0b err=%0b data=%h, required 1/0/%h",
                     part_valid, part_err, part_data, model_data(1'b1));
        end
    endtask

    task automatic test_random;
        int done_at;
        bit fin;
        int err_idx;
        int rdly;
        bit pass;
        logic [WW-1:0] x;
        for (int it = 0; it < 24; it++) begin
            x = '0;
            for (int i = 0; i < int'(NW); i++) begin
                pw[i] = $urandom;
                x = x ^ pw[i];
            end
            pw[NW] = ($urandom_range(0, 3) != 0) ? x : x ^ (32'h1 << $urandom_range(0, 31));
            for (int i = 0; i <= int'(NW); i++) pg[i] = $urandom_range(0, 3);
            err_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NW)) : -1;
            rdly = $urandom_range(0, 3);
            pass = model_pass(err_idx);
            run_readout(err_idx, rdly, -1, 1'b1, done_at, fin);
            n_tests++;
            if (part_valid !== pass || part_err !== !pass || part_data !== model_data(pass)) begin
                n_fail++;
                $display("FAIL random[%0d]: valid=%0b err=%0b data=%h, required %0b/%0b/%h",
                         it, part_valid, part_err, part_data, pass, !pass, model_data(pass));
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_readout();
        test_bad_digest();
        test_otp_err();
        test_gnt_stall();
        test_reset_mid();
        test_err_then_good();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
